// File: rtl/mc_pkg.sv
// Shared definitions for the AXI burst master: FSM state encoding and the
// default AXI widths used as parameter defaults by axi_mst.
package mc_pkg;

   localparam int AXI_ADDR_WIDTH_DEF = 25;
   localparam int AXI_DATA_WIDTH_DEF = 256;
   localparam int AXI_LEN_WIDTH_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AW   = 3'd1,
      ST_W    = 3'd2,
      ST_AR   = 3'd3,
      ST_R    = 3'd4
   } state_e;

endpackage

// File: rtl/axi_mst.sv
// axi_mst: single-outstanding AXI burst master. A command is accepted in
// IDLE, its address phase is issued on AW or AR, then the data beats are
// streamed through W (combinational pass-through of the write payload) or
// captured from R (registered, one cycle of latency). There is no B channel;
// a write finishes on the last W handshake.
// Optional protocol checking on the R channel is enabled by defining
// AXI_MST_CHK_EN; without it err is tied low and rlast is ignored.
module axi_mst
   import mc_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
   parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
   parameter int AXI_LEN_WIDTH  = AXI_LEN_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_rw,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
   input  logic                      wr_data_valid,
   output logic                      wr_data_ready,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   output logic                      rd_data_valid,
   output logic                      rd_data_last,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   output logic                      axi_m_awvalid,
   input  logic                      axi_m_awready,
   output logic [7:0]                axi_m_awlen,
   output logic [AXI_ADDR_WIDTH-1:0] axi_m_awaddr,
   output logic                      axi_m_wvalid,
   input  logic                      axi_m_wready,
   output logic                      axi_m_wlast,
   output logic [AXI_DATA_WIDTH-1:0] axi_m_wdata,
   output logic                      axi_m_arvalid,
   input  logic                      axi_m_arready,
   output logic [7:0]                axi_m_arlen,
   output logic [AXI_ADDR_WIDTH-1:0] axi_m_araddr,
   input  logic                      axi_m_rvalid,
   input  logic                      axi_m_rlast,
   input  logic [AXI_DATA_WIDTH-1:0] axi_m_rdata,
   output logic                      busy,
   output logic                      err
);

   // One spare bit so a 256-beat burst can count past 255 without wrapping.
   localparam int CNT_W = AXI_LEN_WIDTH + 1;

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_LEN_WIDTH-1:0]  len_q, len_d;
   logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                      rd_data_valid_q, rd_data_valid_d;
   logic                      rd_data_last_q, rd_data_last_d;
   logic                      err_q, err_d;
   logic                      last_beat;
   logic                      w_hs;

   assign last_beat = (beat_cnt_q == {1'b0, len_q});
   assign w_hs      = (state_q == ST_W) && wr_data_valid && axi_m_wready;

   // Next-state, command capture, beat counting and read capture.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      len_d           = len_q;
      beat_cnt_d      = beat_cnt_q;
      rd_data_d       = rd_data_q;
      rd_data_valid_d = 1'b0;
      rd_data_last_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d     = cmd_addr;
               len_d      = cmd_len;
               beat_cnt_d = '0;
               state_d    = cmd_rw ? ST_AW : ST_AR;
            end
         end
         ST_AW: begin
            if (axi_m_awready) state_d = ST_W;
         end
         ST_W: begin
            if (w_hs) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (last_beat) state_d = ST_IDLE;
            end
         end
         ST_AR: begin
            if (axi_m_arready) state_d = ST_R;
         end
         ST_R: begin
            if (axi_m_rvalid) begin
               rd_data_d       = axi_m_rdata;
               rd_data_valid_d = 1'b1;
               rd_data_last_d  = last_beat;
               beat_cnt_d      = beat_cnt_q + CNT_W'(1);
               if (last_beat) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef AXI_MST_CHK_EN
   // Sticky R-channel protocol error: stray rvalid, early rlast, missing rlast.
   always_comb begin
      err_d = err_q;
      if (axi_m_rvalid && (state_q != ST_R)) err_d = 1'b1;
      if ((state_q == ST_R) && axi_m_rvalid && (axi_m_rlast != last_beat)) err_d = 1'b1;
   end
`else
   // Checking disabled: err never sets and rlast is not looked at.
   always_comb begin
      err_d = 1'b0;
   end
   logic unused_rlast;
   assign unused_rlast = axi_m_rlast;
`endif

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         len_q           <= '0;
         beat_cnt_q      <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_data_last_q  <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         beat_cnt_q      <= beat_cnt_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_last_q  <= rd_data_last_d;
         err_q           <= err_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign err           = err_q;

   assign axi_m_awvalid = (state_q == ST_AW);
   assign axi_m_awaddr  = addr_q;
   assign axi_m_awlen   = 8'(len_q);
   assign axi_m_arvalid = (state_q == ST_AR);
   assign axi_m_araddr  = addr_q;
   assign axi_m_arlen   = 8'(len_q);

   assign axi_m_wvalid  = (state_q == ST_W) && wr_data_valid;
   assign wr_data_ready = (state_q == ST_W) && axi_m_wready;
   assign axi_m_wlast   = (state_q == ST_W) && last_beat;
   assign axi_m_wdata   = (state_q == ST_W) ? wr_data : '0;

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_data_last  = rd_data_last_q;

endmodule

// File: tb/tb_axi_mst.sv
// Directed testbench for axi_mst: reset state, delayed-AW write, single-beat
// read, 256-beat write with gapped payload, R-channel error checking,
// stray rvalid and reset in the middle of a write burst.
module tb_axi_mst;

   localparam int AW = 25;
   localparam int DW = 256;
   localparam int LW = 8;
`ifdef AXI_MST_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_rw;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          wr_data_valid, wr_data_ready;
   logic [DW-1:0] wr_data;
   logic          rd_data_valid, rd_data_last;
   logic [DW-1:0] rd_data;
   logic          awvalid, awready, wvalid, wready, wlast, arvalid, arready;
   logic [7:0]    awlen, arlen;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, rdata;
   logic          rvalid, rlast;
   logic          busy, err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi_mst #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
      .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last), .rd_data(rd_data),
      .axi_m_awvalid(awvalid), .axi_m_awready(awready), .axi_m_awlen(awlen),
      .axi_m_awaddr(awaddr), .axi_m_wvalid(wvalid), .axi_m_wready(wready),
      .axi_m_wlast(wlast), .axi_m_wdata(wdata), .axi_m_arvalid(arvalid),
      .axi_m_arready(arready), .axi_m_arlen(arlen), .axi_m_araddr(araddr),
      .axi_m_rvalid(rvalid), .axi_m_rlast(rlast), .axi_m_rdata(rdata),
      .busy(busy), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pat(input int seed);
      logic [DW-1:0] v;
      v = {8{32'hC0DE_0000 + 32'(seed)}};
      return v;
   endfunction

   task automatic issue_cmd(input logic rw, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input string name);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = len;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_errors++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, busy, err, awvalid, arvalid, wvalid, wr_data_ready, rd_data_valid, rd_data_last}
          !== 9'b100000000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b want 100000000",
                  {cmd_ready, busy, err, awvalid, arvalid, wvalid, wr_data_ready, rd_data_valid, rd_data_last});
      end
      n_checks++;
      if (awaddr !== '0 || rd_data !== '0) begin
         n_errors++; $display("FAIL reset_data: awaddr %h rd_data %h want 0", awaddr, rd_data);
      end
      $display("test_reset done");
   endtask

   task automatic test_write(input logic [AW-1:0] addr, input int len, input int aw_delay,
                             input bit toggle, input string name);
      int aw_cycles = 0;
      int hs = 0;
      issue_cmd(1'b1, addr, LW'(len), name);
      n_checks++;
      if (awvalid !== 1'b1 || awaddr !== addr || awlen !== 8'(len)) begin
         n_errors++;
         $display("FAIL %s aw: awvalid %b awaddr %h awlen %0d want 1 %h %0d", name, awvalid, awaddr, awlen, addr, len);
      end
      awready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!awvalid) break;
         aw_cycles++;
         if (aw_cycles > aw_delay) awready = 1'b1;
         #1;
         tick();
      end
      awready = 1'b0;
      n_checks++;
      if (aw_cycles != aw_delay + 1) begin
         n_errors++; $display("FAIL %s aw_hold: got %0d cycles want %0d", name, aw_cycles, aw_delay + 1);
      end
      for (int c = 0; c < 1200 && hs <= len; c++) begin
         wready = 1'b1;
         wr_data_valid = toggle ? (c % 2 == 1) : 1'b1;
         wr_data = pat(hs);
         #1;
         if (wvalid && wr_data_ready) begin
            n_checks++;
            if (wlast !== (hs == len) || wdata !== pat(hs)) begin
               n_errors++;
               $display("FAIL %s beat%0d: wlast %b wdata %h want %b %h", name, hs, wlast, wdata, hs == len, pat(hs));
            end
            hs++;
         end
         tick();
      end
      wr_data_valid = 1'b0;
      wready = 1'b0;
      n_checks++;
      if (hs != len + 1) begin
         n_errors++; $display("FAIL %s handshakes: got %0d want %0d", name, hs, len + 1);
      end
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_errors++; $display("FAIL %s done: busy %b cmd_ready %b want 0 1", name, busy, cmd_ready);
      end
      wr_data_valid = 1'b1;
      wready = 1'b1;
      #1;
      n_checks++;
      if (wvalid !== 1'b0 || wr_data_ready !== 1'b0) begin
         n_errors++; $display("FAIL %s w_idle: wvalid %b wr_data_ready %b want 0 0", name, wvalid, wr_data_ready);
      end
      wr_data_valid = 1'b0;
      wready = 1'b0;
      $display("%s: %0d write beats, aw held %0d cycles", name, hs, aw_cycles);
   endtask

   task automatic test_read(input logic [AW-1:0] addr, input int len, input int rlast_beat,
                            input string name);
      issue_cmd(1'b0, addr, LW'(len), name);
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== addr || arlen !== 8'(len)) begin
         n_errors++;
         $display("FAIL %s ar: arvalid %b araddr %h arlen %0d want 1 %h %0d", name, arvalid, araddr, arlen, addr, len);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      for (int b = 0; b <= len; b++) begin
         rvalid = 1'b1;
         rlast = (b == rlast_beat);
         rdata = pat(100 + b);
         tick();
         rvalid = 1'b0;
         rlast = 1'b0;
         n_checks++;
         if (rd_data_valid !== 1'b1 || rd_data_last !== (b == len) || rd_data !== pat(100 + b)) begin
            n_errors++;
            $display("FAIL %s rbeat%0d: valid %b last %b data %h want 1 %b %h",
                     name, b, rd_data_valid, rd_data_last, rd_data, b == len, pat(100 + b));
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL %s rd_done: busy %b want 0", name, busy);
      end
      tick();
      n_checks++;
      if (rd_data_valid !== 1'b0) begin
         n_errors++; $display("FAIL %s rd_valid_drop: got %b want 0", name, rd_data_valid);
      end
      $display("%s: %0d read beats", name, len + 1);
   endtask

   task automatic test_read_err();
      test_read(25'h0000200, 3, 2, "read_early_rlast");
      n_checks++;
      if (err !== CHK) begin
         n_errors++; $display("FAIL err_set: got %b want %b", err, CHK);
      end
      repeat (3) tick();
      n_checks++;
      if (err !== CHK) begin
         n_errors++; $display("FAIL err_sticky: got %b want %b", err, CHK);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL err_clear: got %b want 0", err);
      end
      $display("test_read_err: err after early rlast %b", CHK);
   endtask

   task automatic test_stray_rvalid();
      rvalid = 1'b1; rlast = 1'b1; rdata = pat(7);
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      n_checks++;
      if (err !== CHK || rd_data_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL stray_rvalid: err %b rd_valid %b busy %b want %b 0 0", err, rd_data_valid, busy, CHK);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      $display("test_stray_rvalid done");
   endtask

   task automatic test_rst_mid_write();
      issue_cmd(1'b1, 25'h0000400, 8'd3, "rst_mid");
      awready = 1'b1;
      tick();
      awready = 1'b0;
      wready = 1'b1; wr_data_valid = 1'b1; wr_data = pat(0);
      tick();
      wr_data = pat(1);
      tick();
      wr_data = pat(2);
      #1;
      n_checks++;
      if (wvalid !== 1'b1 || wlast !== 1'b0) begin
         n_errors++; $display("FAIL rst_mid_beat2: wvalid %b wlast %b want 1 0", wvalid, wlast);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || wvalid !== 1'b0 || cmd_ready !== 1'b1 || wr_data_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid_idle: busy %b wvalid %b cmd_ready %b wr_rdy %b want 0 0 1 0",
                  busy, wvalid, cmd_ready, wr_data_ready);
      end
      wr_data_valid = 1'b0; wready = 1'b0;
      test_read(25'h0000040, 1, 1, "read_after_rst");
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++; $display("FAIL rst_mid_err: got %b want 0", err);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data_valid = 1'b0; wr_data = '0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; rdata = '0;
      test_reset();
      test_write(25'h0000100, 3, 2, 1'b0, "write_len3");
      test_read(25'h1FFFFE0, 0, 0, "read_len0");
      test_write(25'h0001000, 255, 0, 1'b1, "write_len255");
      test_read_err();
      test_stray_rvalid();
      test_rst_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
